// File: rtl/conv_encoder_if.sv
// rtl/conv_encoder_if.sv - frame-in / code-beat-out handshake bundle for conv_encoder
// master drives frames and code acceptance; slave is the encoder side.
interface conv_encoder_if #(
  parameter int FRAME_BITS = 192
) ();
  logic [FRAME_BITS-1:0] i_frame_data;
  logic                  i_frame_valid;
  logic                  o_frame_ready;
  logic [3:0]            o_code;
  logic                  o_code_valid;
  logic                  i_code_ready;
  logic                  o_code_last;

  modport master (
    output i_frame_data,
    output i_frame_valid,
    input  o_frame_ready,
    input  o_code,
    input  o_code_valid,
    output i_code_ready,
    input  o_code_last
  );

  modport slave (
    input  i_frame_data,
    input  i_frame_valid,
    output o_frame_ready,
    output o_code,
    output o_code_valid,
    input  i_code_ready,
    output o_code_last
  );
endinterface

// File: rtl/conv_encoder.sv
// rtl/conv_encoder.sv - rate-1/2 convolutional encoder, two data bits per 4-bit code beat
// A latched frame is encoded LSB first, then zero tail bits return the trellis to state 0.
module conv_encoder #(
  parameter int             FRAME_BITS = 192,
  parameter int             K          = 3,
  parameter logic [K-1:0]   G0         = 3'b111,
  parameter logic [K-1:0]   G1         = 3'b101
) (
  input  logic           clk,
  input  logic           rst,
  conv_encoder_if.slave  bus
);

  localparam int DATA_BEATS  = FRAME_BITS / 2;
  localparam int TAIL_BEATS  = K / 2;
  localparam int TOTAL_BEATS = DATA_BEATS + TAIL_BEATS;
  localparam int CNT_W       = $clog2(TOTAL_BEATS + 1);

  localparam logic [CNT_W-1:0] LAST_DATA_CNT = CNT_W'(DATA_BEATS - 1);
  localparam logic [CNT_W-1:0] LAST_BEAT_CNT = CNT_W'(TOTAL_BEATS - 1);

  typedef enum logic [1:0] {
    IDLE,
    ENCODE,
    TAIL
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [FRAME_BITS-1:0] frame_q;
  logic [K-2:0]          enc_state;
  logic [K-2:0]          enc_next;
  logic [CNT_W-1:0]      beat_cnt;

  logic                  in_b0;
  logic                  in_b1;
  logic [K-1:0]          reg_a;
  logic [K-1:0]          reg_b;
  logic [3:0]            beat_code;

  logic                  frame_ready;
  logic                  code_valid;
  logic                  code_last;
  logic                  accept_frame;
  logic                  accept_beat;

  // The frame register is shifted down two bits per accepted beat, so the
  // current pair always sits in bits [1:0]; tail beats feed zeros.
  always_comb begin
    in_b0     = (state == ENCODE) & frame_q[0];
    in_b1     = (state == ENCODE) & frame_q[1];
    reg_a     = {enc_state, in_b0};
    reg_b     = {reg_a[K-2:0], in_b1};
    enc_next  = reg_b[K-2:0];
    beat_code = {^(reg_b & G1), ^(reg_b & G0), ^(reg_a & G1), ^(reg_a & G0)};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    frame_ready  = 1'b0;
    code_valid   = 1'b0;
    code_last    = 1'b0;
    accept_frame = 1'b0;
    accept_beat  = 1'b0;
    case (state)
      IDLE: begin
        frame_ready = 1'b1;
        if (bus.i_frame_valid) begin
          accept_frame = 1'b1;
          state_next   = ENCODE;
        end
      end
      ENCODE: begin
        code_valid = 1'b1;
        if (bus.i_code_ready) begin
          accept_beat = 1'b1;
          if (beat_cnt == LAST_DATA_CNT) begin
            state_next = TAIL;
          end
        end
      end
      TAIL: begin
        code_valid = 1'b1;
        code_last  = (beat_cnt == LAST_BEAT_CNT);
        if (bus.i_code_ready) begin
          accept_beat = 1'b1;
          if (code_last) begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Encoder state and counter move only on an accepted beat, which keeps
  // the presented beat stable across downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_q   <= '0;
      enc_state <= '0;
      beat_cnt  <= '0;
    end else if (accept_frame) begin
      frame_q   <= bus.i_frame_data;
      enc_state <= '0;
      beat_cnt  <= '0;
    end else if (accept_beat) begin
      frame_q   <= frame_q >> 2;
      enc_state <= enc_next;
      beat_cnt  <= code_last ? '0 : beat_cnt + 1'b1;
    end
  end

  assign bus.o_frame_ready = frame_ready;
  assign bus.o_code_valid  = code_valid;
  assign bus.o_code_last   = code_last;
  assign bus.o_code        = code_valid ? beat_code : 4'b0000;

endmodule

// File: tb/tb_conv_encoder.sv
// tb/tb_conv_encoder.sv - directed and model-checked bench for conv_encoder
// Each test task drives one scenario and checks its own results inline.
module tb_conv_encoder;
  localparam int FB = 192;
  localparam int NB = 97;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv_encoder_if #(.FRAME_BITS(FB)) bus ();

  conv_encoder #(.FRAME_BITS(FB), .K(3), .G0(3'b111), .G1(3'b101)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests_run = 0;
  int tests_failed = 0;

  logic [3:0] got_code [0:NB+7];
  logic       got_last [0:NB+7];
  logic [3:0] exp_code [0:NB-1];
  int         got_n;
  bit         timed_out;
  int         bubbles;
  int         stall_err;
  bit         first_ok;

  function automatic logic [FB-1:0] rand_frame();
    logic [FB-1:0] r;
    for (int i = 0; i < FB / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Bit-serial reference: c0 = u[t]^u[t-1]^u[t-2], c1 = u[t]^u[t-2].
  task automatic build_expected(input logic [FB-1:0] data);
    logic [FB+1:0] u;
    logic a, b, c;
    int t;
    u = {2'b00, data};
    for (int n = 0; n < NB; n++) begin
      for (int j = 0; j < 2; j++) begin
        t = 2 * n + j;
        a = u[t];
        b = (t >= 1) ? u[t-1] : 1'b0;
        c = (t >= 2) ? u[t-2] : 1'b0;
        exp_code[n][2*j]   = a ^ b ^ c;
        exp_code[n][2*j+1] = a ^ c;
      end
    end
  endtask

  // mode 0: ready always high; mode 1: ready toggles 1/0. stop_after>0 ends early.
  task automatic run_frame(input logic [FB-1:0] data, input int mode, input bit hold,
                           input int stop_after);
    int cyc;
    bit done, started, was_stalled;
    logic [3:0] held_code;
    logic held_last;
    got_n = 0; timed_out = 0; bubbles = 0; stall_err = 0; first_ok = 0;
    done = 0; started = 0; was_stalled = 0; cyc = 0;
    held_code = '0; held_last = 1'b0;
    while (!bus.o_frame_ready && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    if (!bus.o_frame_ready) timed_out = 1;
    bus.i_frame_data  = data;
    bus.i_frame_valid = 1'b1;
    @(posedge clk); #1;
    first_ok = bus.o_code_valid;
    if (hold) bus.i_frame_data = ~data;
    else bus.i_frame_valid = 1'b0;
    cyc = 0;
    while (!done && !timed_out) begin
      if (was_stalled && (bus.o_code !== held_code || bus.o_code_last !== held_last))
        stall_err++;
      bus.i_code_ready = (mode == 0) ? 1'b1 : (cyc % 2 == 0);
      if (!bus.o_code_valid) begin
        if (started) bubbles++;
      end else begin
        started = 1;
        if (bus.i_code_ready) begin
          if (got_n < NB + 8) begin
            got_code[got_n] = bus.o_code;
            got_last[got_n] = bus.o_code_last;
          end
          got_n++;
          if (bus.o_code_last === 1'b1 || got_n == stop_after) done = 1;
        end
      end
      was_stalled = bus.o_code_valid && !bus.i_code_ready;
      held_code = bus.o_code;
      held_last = bus.o_code_last;
      @(posedge clk); #1; cyc++;
      if (cyc > 4 * NB) timed_out = 1;
    end
    bus.i_frame_valid = 1'b0;
    bus.i_code_ready  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_frame_valid = 1'b0;
    bus.i_frame_data  = '0;
    bus.i_code_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tests_run++;
    if (bus.o_code !== 4'b0000) begin
      tests_failed++; $display("FAIL reset_code: got %b expected 0000", bus.o_code);
    end
    tests_run++;
    if (bus.o_code_valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_valid: got %b expected 0", bus.o_code_valid);
    end
    tests_run++;
    if (bus.o_code_last !== 1'b0) begin
      tests_failed++; $display("FAIL reset_last: got %b expected 0", bus.o_code_last);
    end
    @(posedge clk); #1;
    tests_run++;
    if (bus.o_frame_ready !== 1'b1) begin
      tests_failed++; $display("FAIL reset_frame_ready: got %b expected 1", bus.o_frame_ready);
    end
  endtask

  task automatic check_frame_shape(input string name);
    int nlast;
    nlast = 0;
    for (int i = 0; i < got_n && i < NB + 8; i++) if (got_last[i]) nlast++;
    tests_run++;
    if (timed_out || got_n != NB) begin
      tests_failed++;
      $display("FAIL %s_beats: got %0d beats (timeout=%0d) expected %0d", name, got_n, timed_out, NB);
    end
    tests_run++;
    if (nlast != 1 || got_last[NB-1] !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s_last: got %0d last flags, final=%b expected 1 on beat %0d", name, nlast, got_last[NB-1], NB - 1);
    end
    tests_run++;
    if (!first_ok || bubbles != 0) begin
      tests_failed++;
      $display("FAIL %s_stream: got first_valid=%0d bubbles=%0d expected 1 and 0", name, first_ok, bubbles);
    end
    tests_run++;
    if (bus.o_code_valid !== 1'b0 || bus.o_frame_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s_after_last: got valid=%b frame_ready=%b expected 0 and 1", name, bus.o_code_valid, bus.o_frame_ready);
    end
  endtask

  task automatic test_all_zero();
    int nz;
    run_frame('0, 0, 1'b0, 0);
    check_frame_shape("all_zero");
    nz = 0;
    for (int i = 0; i < NB && i < got_n; i++) if (got_code[i] !== 4'b0000) nz++;
    tests_run++;
    if (nz != 0) begin
      tests_failed++; $display("FAIL all_zero_codes: got %0d nonzero beats expected 0", nz);
    end
  endtask

  task automatic test_impulse_first(input int mode, input string name);
    logic [FB-1:0] d;
    int nz;
    d = '0;
    d[0] = 1'b1;
    run_frame(d, mode, 1'b0, 0);
    check_frame_shape(name);
    tests_run++;
    if (got_code[0] !== 4'b0111) begin
      tests_failed++; $display("FAIL %s_beat0: got %b expected 0111", name, got_code[0]);
    end
    tests_run++;
    if (got_code[1] !== 4'b0011) begin
      tests_failed++; $display("FAIL %s_beat1: got %b expected 0011", name, got_code[1]);
    end
    nz = 0;
    for (int i = 2; i < NB && i < got_n; i++) if (got_code[i] !== 4'b0000) nz++;
    tests_run++;
    if (nz != 0) begin
      tests_failed++; $display("FAIL %s_rest: got %0d nonzero beats expected 0", name, nz);
    end
    if (mode != 0) begin
      tests_run++;
      if (stall_err != 0) begin
        tests_failed++; $display("FAIL %s_stable: got %0d changes while stalled expected 0", name, stall_err);
      end
    end
  endtask

  task automatic test_impulse_last();
    logic [FB-1:0] d;
    int nz;
    d = '0;
    d[FB-1] = 1'b1;
    run_frame(d, 0, 1'b0, 0);
    check_frame_shape("impulse_last");
    nz = 0;
    for (int i = 0; i < NB - 2 && i < got_n; i++) if (got_code[i] !== 4'b0000) nz++;
    tests_run++;
    if (nz != 0) begin
      tests_failed++; $display("FAIL impulse_last_lead: got %0d nonzero beats expected 0", nz);
    end
    tests_run++;
    if (got_code[NB-2] !== 4'b1100) begin
      tests_failed++; $display("FAIL impulse_last_beat95: got %b expected 1100", got_code[NB-2]);
    end
    tests_run++;
    if (got_code[NB-1] !== 4'b1101) begin
      tests_failed++; $display("FAIL impulse_last_tail: got %b expected 1101", got_code[NB-1]);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [FB-1:0] d;
    int bad;
    d = rand_frame();
    build_expected(d);
    run_frame(d, 0, 1'b0, 40);
    bad = 0;
    for (int i = 0; i < got_n && i < NB; i++) if (got_code[i] !== exp_code[i]) bad++;
    tests_run++;
    if (got_n != 40 || bad != 0) begin
      tests_failed++; $display("FAIL midrst_prefix: got %0d beats, %0d wrong expected 40 and 0", got_n, bad);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests_run++;
    if (bus.o_code_valid !== 1'b0 || bus.o_frame_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrst_state: got valid=%b frame_ready=%b expected 0 and 1", bus.o_code_valid, bus.o_frame_ready);
    end
    d = rand_frame();
    build_expected(d);
    run_frame(d, 0, 1'b0, 0);
    check_frame_shape("midrst_restart");
    bad = 0;
    for (int i = 0; i < got_n && i < NB; i++) if (got_code[i] !== exp_code[i]) bad++;
    tests_run++;
    if (bad != 0) begin
      tests_failed++; $display("FAIL midrst_restart_codes: got %0d wrong beats expected 0", bad);
    end
  endtask

  task automatic test_back_to_back();
    logic [FB-1:0] d;
    int bad;
    for (int f = 0; f < 3; f++) begin
      d = rand_frame();
      build_expected(d);
      run_frame(d, (f == 2) ? 1 : 0, f == 1, 0);
      check_frame_shape($sformatf("b2b%0d", f));
      bad = 0;
      for (int i = 0; i < got_n && i < NB; i++) if (got_code[i] !== exp_code[i]) bad++;
      tests_run++;
      if (bad != 0) begin
        tests_failed++; $display("FAIL b2b%0d_codes: got %0d wrong beats expected 0", f, bad);
      end
    end
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_impulse_first(0, "impulse_first");
    test_impulse_last();
    test_impulse_first(1, "stall");
    test_reset_mid_frame();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
